// File: rtl/uart_master_cmd.sv
// uart_master_cmd: turns UART receiver bytes into 16-bit bus reads/writes.
// Write: 'W' AH AL DH DL (no reply). Read: 'R' AH AL, reply DH DL via tx handshake.
// Optional bus-ack timeout is compiled in with `define UART_MASTER_TIMEOUT_EN.
module uart_master_cmd #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_pulse,
  output logic [15:0] o_addr,
  output logic [15:0] o_dat,
  input  logic [15:0] i_dat,
  output logic        o_we,
  output logic        o_cs,
  input  logic        i_ack,
  output logic [7:0]  o_tx_dat,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_overrun,
  output logic        o_err
);

  typedef enum logic [2:0] {
    StCmd,
    StAddrH,
    StAddrL,
    StDataH,
    StDataL,
    StBus,
    StRespH,
    StRespL
  } state_t;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;

  state_t      state_q, state_d;
  logic        isWrite_q, isWrite_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dat_q, dat_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [7:0]  txDat_q, txDat_d;
  logic        txValid_q, txValid_d;
  logic        overrun_q, overrun_d;
  logic        err_q, err_d;
  logic        busy;
  logic        timeoutHit;

`ifdef UART_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [15:0] count_q, count_d;

  // Cycle counter for the current bus access; zero whenever we are outside BUS.
  always_comb begin
    count_d    = 16'd0;
    timeoutHit = 1'b0;
    if (state_q == StBus) begin
      count_d    = count_q + 16'd1;
      timeoutHit = !i_ack && (count_q == TimeoutLast);
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  logic unusedTimeout;

  assign unusedTimeout = |TIMEOUT;
  assign timeoutHit    = 1'b0;
`endif

  assign busy = (state_q == StBus) || (state_q == StRespH) || (state_q == StRespL);

  // Command parser / bus FSM next state, plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    isWrite_d = isWrite_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StCmd: begin
        if (i_rx_pulse) begin
          if (i_rx_dat == CmdWrite) begin
            isWrite_d = 1'b1;
            state_d   = StAddrH;
          end else if (i_rx_dat == CmdRead) begin
            isWrite_d = 1'b0;
            state_d   = StAddrH;
          end
        end
      end
      StAddrH: begin
        if (i_rx_pulse) begin
          addr_d[15:8] = i_rx_dat;
          state_d      = StAddrL;
        end
      end
      StAddrL: begin
        if (i_rx_pulse) begin
          addr_d[7:0] = i_rx_dat;
          state_d     = isWrite_q ? StDataH : StBus;
        end
      end
      StDataH: begin
        if (i_rx_pulse) begin
          dat_d[15:8] = i_rx_dat;
          state_d     = StDataL;
        end
      end
      StDataL: begin
        if (i_rx_pulse) begin
          dat_d[7:0] = i_rx_dat;
          state_d    = StBus;
        end
      end
      StBus: begin
        if (i_ack) begin
          if (isWrite_q) begin
            state_d = StCmd;
          end else begin
            rdata_d = i_dat;
            state_d = StRespH;
          end
        end else if (timeoutHit) begin
          if (isWrite_q) begin
            state_d = StCmd;
          end else begin
            rdata_d = 16'hFFFF;
            state_d = StRespH;
          end
        end
      end
      StRespH: begin
        if (i_tx_ready) begin
          state_d = StRespL;
        end
      end
      StRespL: begin
        if (i_tx_ready) begin
          state_d = StCmd;
        end
      end
      default: begin
        state_d = StCmd;
      end
    endcase

    cs_d      = (state_d == StBus);
    we_d      = (state_d == StBus) && isWrite_d;
    txValid_d = (state_d == StRespH) || (state_d == StRespL);
    txDat_d   = txDat_q;
    if (state_d == StRespH) begin
      txDat_d = rdata_d[15:8];
    end else if (state_d == StRespL) begin
      txDat_d = rdata_d[7:0];
    end
    overrun_d = i_rx_pulse && busy;
    err_d     = timeoutHit;
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StCmd;
      isWrite_q <= 1'b0;
      addr_q    <= 16'd0;
      dat_q     <= 16'd0;
      rdata_q   <= 16'd0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      txDat_q   <= 8'd0;
      txValid_q <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      isWrite_q <= isWrite_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      rdata_q   <= rdata_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      txDat_q   <= txDat_d;
      txValid_q <= txValid_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign o_addr     = addr_q;
  assign o_dat      = dat_q;
  assign o_we       = we_q;
  assign o_cs       = cs_q;
  assign o_tx_dat   = txDat_q;
  assign o_tx_valid = txValid_q;
  assign o_overrun  = overrun_q;
  assign o_err      = err_q;

endmodule
